// File: rtl/graph_pkg.sv
// Shared types for the graph traversal pipeline: address/word types, the
// vertex expansion state encoding and the neighbour-count saturation helper.
package graph_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FEAT = 2'd1,
        EMIT = 2'd2
    } expand_state_t;

    localparam int DEFAULT_DIM = 2;

    // Clamp a raw neighbour count to the per-vertex limit.
    function automatic word_t sat_count(input word_t raw, input word_t limit);
        word_t res;
        if (raw > limit) begin
            res = limit;
        end else begin
            res = raw;
        end
        return res;
    endfunction

endpackage

// File: rtl/vertex_expand.sv
// Vertex expander: latches one fetched record, emits its feature vector, then
// streams its neighbour addresses. Optional counters under VERTEX_EXPAND_STATS_EN.
module vertex_expand
    import graph_pkg::*;
#(
    parameter int    DIM        = DEFAULT_DIM,
    parameter int    MAX_NEIGH  = 64,
    parameter addr_t NEIGH_BASE = 32'h0000_0000
) (
    input  logic  clk_in,
    input  logic  rst_in,
    input  logic  rec_valid_in,
    input  addr_t rowidx_in,
    input  word_t data_in [DIM:0],
    output logic  rec_ready_out,
    output word_t feat_out [DIM-1:0],
    output logic  feat_valid_out,
    input  logic  feat_ready_in,
    output addr_t neigh_addr_out,
    output logic  neigh_valid_out,
    output logic  neigh_last_out,
    input  logic  neigh_ready_in,
    output logic  done_out,
`ifdef VERTEX_EXPAND_STATS_EN
    output word_t vtx_count_out,
    output word_t neigh_count_out,
`endif
    output logic  trunc_out
);

    localparam word_t MAX_NEIGH_W = word_t'(MAX_NEIGH);

    expand_state_t state_r;
    addr_t         base_r;
    word_t         cnt_r;
    word_t         idx_r;
    logic          feat_hs_s;
    logic          neigh_hs_s;

    assign feat_hs_s  = feat_valid_out && feat_ready_in;
    assign neigh_hs_s = neigh_valid_out && neigh_ready_in;

    // done_out marks the completing handshake itself, so it is decoded from registered state in that cycle.
    always_comb begin
        done_out = 1'b0;
        if (rst_in) begin
            done_out = 1'b0;
        end else if (feat_hs_s && (cnt_r == 32'd0)) begin
            done_out = 1'b1;
        end else if (neigh_hs_s && neigh_last_out) begin
            done_out = 1'b1;
        end else begin
            done_out = 1'b0;
        end
    end

    // Expansion FSM with all handshake outputs registered.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r         <= IDLE;
            base_r          <= 32'd0;
            cnt_r           <= 32'd0;
            idx_r           <= 32'd0;
            rec_ready_out   <= 1'b1;
            feat_valid_out  <= 1'b0;
            neigh_valid_out <= 1'b0;
            neigh_last_out  <= 1'b0;
            neigh_addr_out  <= 32'd0;
            trunc_out       <= 1'b0;
            for (int i = 0; i < DIM; i++) begin
                feat_out[i] <= 32'd0;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (rec_valid_in && rec_ready_out) begin
                        base_r <= rowidx_in;
                        cnt_r  <= sat_count(data_in[0], MAX_NEIGH_W);
                        idx_r  <= 32'd0;
                        if (data_in[0] > MAX_NEIGH_W) begin
                            trunc_out <= 1'b1;
                        end
                        for (int i = 0; i < DIM; i++) begin
                            feat_out[i] <= data_in[i+1];
                        end
                        rec_ready_out  <= 1'b0;
                        feat_valid_out <= 1'b1;
                        state_r        <= FEAT;
                    end
                end
                FEAT: begin
                    if (feat_ready_in) begin
                        feat_valid_out <= 1'b0;
                        if (cnt_r == 32'd0) begin
                            rec_ready_out <= 1'b1;
                            state_r       <= IDLE;
                        end else begin
                            neigh_valid_out <= 1'b1;
                            neigh_addr_out  <= NEIGH_BASE + base_r;
                            neigh_last_out  <= (cnt_r == 32'd1);
                            state_r         <= EMIT;
                        end
                    end
                end
                EMIT: begin
                    if (neigh_ready_in) begin
                        if (neigh_last_out) begin
                            neigh_valid_out <= 1'b0;
                            neigh_last_out  <= 1'b0;
                            rec_ready_out   <= 1'b1;
                            state_r         <= IDLE;
                        end else begin
                            // Addresses wrap modulo 2^32 by construction of the 32-bit sum.
                            idx_r          <= idx_r + 32'd1;
                            neigh_addr_out <= NEIGH_BASE + base_r + idx_r + 32'd1;
                            neigh_last_out <= ((idx_r + 32'd2) == cnt_r);
                        end
                    end
                end
                default: begin
                    state_r         <= IDLE;
                    rec_ready_out   <= 1'b1;
                    feat_valid_out  <= 1'b0;
                    neigh_valid_out <= 1'b0;
                    neigh_last_out  <= 1'b0;
                end
            endcase
        end
    end

`ifdef VERTEX_EXPAND_STATS_EN
    // Free-running vertex and neighbour counters, wrapping at 2^32.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            vtx_count_out   <= 32'd0;
            neigh_count_out <= 32'd0;
        end else begin
            if (done_out) begin
                vtx_count_out <= vtx_count_out + 32'd1;
            end
            if (neigh_hs_s) begin
                neigh_count_out <= neigh_count_out + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vertex_expand.sv
// Scoreboard bench for vertex_expand: stimulus pushes expected beats, a
// negedge monitor pops and compares them on every handshake.
module tb_vertex_expand;

    localparam int DIM  = 2;
    localparam int MAXN = 64;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rec_valid, rec_ready, feat_valid, feat_ready;
    logic        nvalid, nlast, nready, done, trunc;
    logic [31:0] rowidx, naddr;
    logic [31:0] data [DIM:0];
    logic [31:0] feat [DIM-1:0];

    logic        w_rec_valid, w_rec_ready, w_feat_valid, w_nvalid, w_nlast, w_done, w_trunc;
    logic        w_ready;
    logic [31:0] w_rowidx, w_naddr;
    logic [31:0] w_data [DIM:0];
    logic [31:0] w_feat [DIM-1:0];

`ifdef VERTEX_EXPAND_STATS_EN
    logic [31:0] vcnt, ncnt, w_vcnt, w_ncnt;
`endif

    vertex_expand #(.DIM(DIM), .MAX_NEIGH(MAXN), .NEIGH_BASE(32'h0000_0000)) dut (
        .clk_in(clk), .rst_in(rst), .rec_valid_in(rec_valid), .rowidx_in(rowidx),
        .data_in(data), .rec_ready_out(rec_ready), .feat_out(feat),
        .feat_valid_out(feat_valid), .feat_ready_in(feat_ready),
        .neigh_addr_out(naddr), .neigh_valid_out(nvalid), .neigh_last_out(nlast),
        .neigh_ready_in(nready), .done_out(done),
`ifdef VERTEX_EXPAND_STATS_EN
        .vtx_count_out(vcnt), .neigh_count_out(ncnt),
`endif
        .trunc_out(trunc)
    );

    vertex_expand #(.DIM(DIM), .MAX_NEIGH(MAXN), .NEIGH_BASE(32'hFFFF_FFFE)) dut_wrap (
        .clk_in(clk), .rst_in(rst), .rec_valid_in(w_rec_valid), .rowidx_in(w_rowidx),
        .data_in(w_data), .rec_ready_out(w_rec_ready), .feat_out(w_feat),
        .feat_valid_out(w_feat_valid), .feat_ready_in(w_ready),
        .neigh_addr_out(w_naddr), .neigh_valid_out(w_nvalid), .neigh_last_out(w_nlast),
        .neigh_ready_in(w_ready), .done_out(w_done),
`ifdef VERTEX_EXPAND_STATS_EN
        .vtx_count_out(w_vcnt), .neigh_count_out(w_ncnt),
`endif
        .trunc_out(w_trunc)
    );

    typedef struct {
        logic [31:0] f0;
        logic [31:0] f1;
        int          cnt;
        bit          trunc;
    } feat_exp_t;

    feat_exp_t   fq[$];
    logic [32:0] aq[$];
    bit          npat[$];
    int          errors = 0;
    int          checks = 0;
    int          mode   = 0;
    bit          model_trunc = 1'b0;
    int          mon_vtx = 0;
    int          mon_neigh = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Ready drivers: 0 always ready, 1 random, 2 pattern on neighbour beats, 3 stalled.
    always @(posedge clk) begin
        #1;
        if (mode == 1) begin
            feat_ready = ($urandom % 4) != 0;
            nready     = ($urandom % 3) != 0;
        end else if (mode == 2) begin
            feat_ready = 1'b1;
            if (nvalid && npat.size() > 0) nready = npat.pop_front();
            else nready = 1'b1;
        end else if (mode == 3) begin
            feat_ready = 1'b0;
            nready     = 1'b0;
        end else begin
            feat_ready = 1'b1;
            nready     = 1'b1;
        end
    end

    feat_exp_t   m_e;
    logic [32:0] m_a;
    bit          m_exp_done;
    bit          n_stall, f_stall;
    logic [32:0] n_hold;
    logic [31:0] f_hold;

    // Monitor: compares every handshake against the scoreboard queues.
    always @(negedge clk) begin
        if (rst) begin
            n_stall = 1'b0;
            f_stall = 1'b0;
        end else begin
            m_exp_done = 1'b0;
            if (n_stall) begin
                chk("neigh_hold_valid", {31'd0, nvalid}, 32'd1);
                chk("neigh_hold_addr", naddr, n_hold[31:0]);
            end
            if (f_stall) begin
                chk("feat_hold_valid", {31'd0, feat_valid}, 32'd1);
                chk("feat_hold_data", feat[0], f_hold);
            end
            if (feat_valid && feat_ready) begin
                if (fq.size() == 0) begin
                    chk("feat_unexpected", 32'd1, 32'd0);
                end else begin
                    m_e = fq.pop_front();
                    chk("feat0", feat[0], m_e.f0);
                    chk("feat1", feat[1], m_e.f1);
                    chk("trunc", {31'd0, trunc}, {31'd0, m_e.trunc});
                    m_exp_done = (m_e.cnt == 0);
                end
            end
            if (nvalid && nready) begin
                if (aq.size() == 0) begin
                    chk("neigh_unexpected", naddr, 32'hDEAD_BEEF);
                end else begin
                    m_a = aq.pop_front();
                    chk("neigh_addr", naddr, m_a[31:0]);
                    chk("neigh_last", {31'd0, nlast}, {31'd0, m_a[32]});
                    m_exp_done = m_a[32];
                end
`ifdef VERTEX_EXPAND_STATS_EN
                chk("neigh_count", ncnt, 32'(mon_neigh));
                mon_neigh++;
`endif
            end
            chk("done", {31'd0, done}, {31'd0, m_exp_done});
`ifdef VERTEX_EXPAND_STATS_EN
            if (m_exp_done) begin
                chk("vtx_count", vcnt, 32'(mon_vtx));
                mon_vtx++;
            end
`endif
            n_stall = nvalid && !nready;
            n_hold  = {nlast, naddr};
            f_stall = feat_valid && !feat_ready;
            f_hold  = feat[0];
        end
    end

    task automatic send(input logic [31:0] ri, input logic [31:0] cnt,
                        input logic [31:0] f0, input logic [31:0] f1);
        feat_exp_t e;
        int        sat;
        bit        ok = 1'b0;
        @(posedge clk); #1;
        rec_valid = 1'b1; rowidx = ri; data[0] = cnt; data[1] = f0; data[2] = f1;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (rec_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            chk("accept_timeout", 32'd0, 32'd1);
        end else begin
            sat = (cnt > MAXN) ? MAXN : int'(cnt);
            if (cnt > MAXN) model_trunc = 1'b1;
            e.f0 = f0; e.f1 = f1; e.cnt = sat; e.trunc = model_trunc;
            fq.push_back(e);
            for (int i = 0; i < sat; i++) aq.push_back({(i == sat - 1), ri + 32'(i)});
        end
        @(posedge clk); #1;
        rec_valid = 1'b0; data[0] = $urandom; rowidx = $urandom;
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (fq.size() == 0 && aq.size() == 0 && !feat_valid && !nvalid) begin
                ok = 1'b1; break;
            end
        end
        if (!ok) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    logic [31:0] wexp [4];
    int          wn;
    bit          seen;

    initial begin
        rst = 1'b1; rec_valid = 1'b0; rowidx = 32'd0; feat_ready = 1'b1; nready = 1'b1;
        w_rec_valid = 1'b0; w_rowidx = 32'd0; w_ready = 1'b1;
        for (int i = 0; i <= DIM; i++) begin data[i] = 32'd0; w_data[i] = 32'd0; end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_rec_ready", {31'd0, rec_ready}, 32'd1);
        chk("rst_valids", {29'd0, feat_valid, nvalid, done}, 32'd0);
        chk("rst_trunc", {31'd0, trunc}, 32'd0);
        chk("rst_addr", naddr, 32'd0);
        chk("rst_feat", feat[0] | feat[1], 32'd0);

        // Basic vertex, then check the single idle turnaround cycle.
        send(32'd10, 32'd3, 32'd7, 32'd9);
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (done) begin seen = 1'b1; break; end
        end
        chk("basic_done_seen", {31'd0, seen}, 32'd1);
        @(negedge clk);
        chk("basic_ready_back", {31'd0, rec_ready}, 32'd1);
        drain();

        send(32'd50, 32'd0, 32'd1, 32'd2);
        drain();

        mode = 2;
        npat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        send(32'd100, 32'd3, 32'd4, 32'd5);
        drain();
        mode = 0;

        send(32'd1000, 32'd200, 32'hAAAA_0000, 32'h5555_0000);
        drain();
        chk("trunc_sticky", {31'd0, trunc}, 32'd1);
        send(32'd2000, 32'd2, 32'd11, 32'd12);
        drain();

        // Randomized vertices with random backpressure, issued back to back.
        mode = 1;
        for (int v = 0; v < 25; v++) begin
            send($urandom, (($urandom % 8) == 0) ? 32'(65 + $urandom % 10) : 32'($urandom % 9),
                 $urandom, $urandom);
        end
        drain();
        mode = 0;
        @(posedge clk);

        // Wrap-around on the second instance.
        wexp[0] = 32'hFFFF_FFFE; wexp[1] = 32'hFFFF_FFFF; wexp[2] = 32'h0; wexp[3] = 32'h1;
        @(posedge clk); #1;
        w_rec_valid = 1'b1; w_rowidx = 32'd0; w_data[0] = 32'd4; w_data[1] = 32'd1; w_data[2] = 32'd2;
        @(posedge clk); #1;
        w_rec_valid = 1'b0;
        wn = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (w_nvalid && wn < 4) begin
                chk("wrap_addr", w_naddr, wexp[wn]);
                chk("wrap_last", {31'd0, w_nlast}, {31'd0, (wn == 3)});
                wn++;
            end
        end
        chk("wrap_count", 32'(wn), 32'd4);

        // Reset after the second of five addresses.
        send(32'd500, 32'd5, 32'd3, 32'd4);
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (nvalid && nready && naddr == 32'd501) begin seen = 1'b1; break; end
        end
        chk("rst_mid_reached", {31'd0, seen}, 32'd1);
        mode = 3;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        fq.delete(); aq.delete();
        model_trunc = 1'b0; mon_vtx = 0; mon_neigh = 0; mode = 0;
        @(negedge clk);
        chk("rst_mid_valids", {30'd0, feat_valid, nvalid}, 32'd0);
        chk("rst_mid_ready", {31'd0, rec_ready}, 32'd1);
        chk("rst_mid_trunc", {31'd0, trunc}, 32'd0);
`ifdef VERTEX_EXPAND_STATS_EN
        chk("rst_mid_vcnt", vcnt, 32'd0);
        chk("rst_mid_ncnt", ncnt, 32'd0);
`endif
        send(32'd700, 32'd2, 32'd8, 32'd9);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
